// File: rtl/kfpga_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader: FSM state
// encoding, CRC-8 constants and the bitstream word-count helper.
package kfpga_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } cfg_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Number of bitstream words needed to cover all configuration bits.
  function automatic int cfg_nwords(input int config_bits, input int word_w);
    return (config_bits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/crc8_update.sv
// Combinational CRC-8 step: folds one byte, MSB first, into the running CRC
// (poly 0x07, no reflection).
module crc8_update
  import kfpga_cfg_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/config_word_loader.sv
// Double-buffered configuration loader: assembles a word-serial bitstream into
// a shadow register and commits it atomically. CONFIG_WORD_LOADER_CRC_EN adds a CRC-8 trailer check.
module config_word_loader
  import kfpga_cfg_pkg::*;
#(
  parameter int CONFIG_BITS = 96,
  parameter int WORD_W      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WORD_W-1:0]      data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [CONFIG_BITS-1:0] config_out,
  output logic                   config_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             state_dbg
);

  // Handshake: a word transfers on a rising edge where data_valid and
  // data_ready are both high; data_ready is high exactly while in LOAD and
  // does not depend on data_valid. An abort in the same cycle wins.

  localparam int NWORDS = cfg_nwords(CONFIG_BITS, WORD_W);
`ifdef CONFIG_WORD_LOADER_CRC_EN
  localparam int LAST_IDX = NWORDS;
`else
  localparam int LAST_IDX = NWORDS - 1;
`endif
  localparam int CNT_W = $clog2(NWORDS + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);

  cfg_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CONFIG_BITS-1:0] shadow_q, shadow_d;
  logic [CONFIG_BITS-1:0] cfg_q, cfg_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   done_q, done_d;

`ifdef CONFIG_WORD_LOADER_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic [7:0] crc_rx_q, crc_rx_d;
  logic [7:0] crc_next;
  logic       error_q, error_d;

  crc8_update u_crc8 (
    .crc_in  (crc_q),
    .data_in (data_in),
    .crc_out (crc_next)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    done_d      = 1'b0;
`ifdef CONFIG_WORD_LOADER_CRC_EN
    crc_d       = crc_q;
    crc_rx_d    = crc_rx_q;
    error_d     = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          shadow_d = '0;
`ifdef CONFIG_WORD_LOADER_CRC_EN
          crc_d    = CRC8_INIT;
          error_d  = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (data_valid) begin
          cnt_d = cnt_q + 1'b1;
          // Bits beyond CONFIG_BITS in the last word have no destination.
          for (int b = 0; b < CONFIG_BITS; b++) begin
            if (int'(cnt_q) == b / WORD_W) shadow_d[b] = data_in[b % WORD_W];
          end
`ifdef CONFIG_WORD_LOADER_CRC_EN
          if (int'(cnt_q) < NWORDS) crc_d = crc_next;
          else                      crc_rx_d = data_in;
          if (cnt_q == LAST_CNT) state_d = ST_CHECK;
`else
          if (cnt_q == LAST_CNT) state_d = ST_COMMIT;
`endif
        end
      end
`ifdef CONFIG_WORD_LOADER_CRC_EN
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (crc_q == crc_rx_q) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
`endif
      ST_COMMIT: begin
        cfg_d       = shadow_q;
        cfg_valid_d = 1'b1;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      done_q      <= done_d;
    end
  end

`ifdef CONFIG_WORD_LOADER_CRC_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_q    <= CRC8_INIT;
      crc_rx_q <= 8'h00;
      error_q  <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_rx_q <= crc_rx_d;
      error_q  <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign data_ready   = (state_q == ST_LOAD);
  assign busy         = (state_q != ST_IDLE);
  assign config_out   = cfg_q;
  assign config_valid = cfg_valid_q;
  assign done         = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_config_word_loader.sv
// Directed bench for config_word_loader: default 96-bit instance plus an
// 18-bit instance for last-word truncation; CRC cases under CONFIG_WORD_LOADER_CRC_EN.
module tb_config_word_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start_b = 1'b0, start_s = 1'b0, abort = 1'b0, data_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;

  logic        data_ready_b, config_valid_b, busy_b, done_b, error_b;
  logic [95:0] config_out_b;
  logic [1:0]  state_dbg_b;
  logic        data_ready_s, config_valid_s, busy_s, done_s, error_s;
  logic [17:0] config_out_s;
  logic [1:0]  state_dbg_s;

  int checks = 0;
  int errors = 0;
  logic [96:0] exp_q[$];

  config_word_loader #(.CONFIG_BITS(96), .WORD_W(8)) u_dut (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready_b),
    .config_out(config_out_b), .config_valid(config_valid_b), .busy(busy_b),
    .done(done_b), .error(error_b), .state_dbg(state_dbg_b)
  );

  config_word_loader #(.CONFIG_BITS(18), .WORD_W(8)) u_small (
    .clock(clock), .reset(reset), .start(start_s), .abort(abort),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready_s),
    .config_out(config_out_s), .config_valid(config_valid_s), .busy(busy_s),
    .done(done_s), .error(error_s), .state_dbg(state_dbg_s)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ b[i]) c = (c << 1) ^ 8'h07;
      else             c = c << 1;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  // Feed 12 words (base+k, or constant base) with optional stall gaps,
  // a mid-load start pulse at start_at, or an abort at abort_at.
  task automatic send_big(input logic [7:0] base, input bit inc, input int gap,
                          input int start_at, input int abort_at, input bit crc_flip);
    logic [7:0] crc;
    int rdy;
    crc = 8'h00;
    rdy = 0;
    for (int k = 0; k < 12; k++) begin
      data_in    = inc ? base + 8'(k) : base;
      data_valid = 1'b1;
      start_b    = (k == start_at);
      abort      = (k == abort_at);
      crc        = crc8_step(crc, data_in);
      if (data_ready_b) rdy++;
      tick();
      start_b = 1'b0;
      if (k == abort_at) begin
        abort      = 1'b0;
        data_valid = 1'b0;
        return;
      end
      if (gap > 0 && k < 11) begin
        data_valid = 1'b0;
        repeat (gap) begin
          chk("stall_ready", data_ready_b, 1);
          tick();
        end
      end
    end
`ifdef CONFIG_WORD_LOADER_CRC_EN
    data_in = crc ^ {7'b0, crc_flip};
    chk("crc_word_ready", data_ready_b, 1);
    tick();
`endif
    data_valid = 1'b0;
    chk("ready_cycles", rdy, 12);
  endtask

  task automatic expect_commit(input logic [95:0] old_cfg, input logic [95:0] new_cfg);
    exp_q.push_back({1'b0, new_cfg});
    chk("ready_after_last", data_ready_b, 0);
    chk("no_partial", config_out_b, old_cfg);
`ifdef CONFIG_WORD_LOADER_CRC_EN
    tick();
    chk("no_partial_check", config_out_b, old_cfg);
`endif
    tick();
    chk("commit_cfg", config_out_b, new_cfg);
    chk("commit_done", done_b, 1);
    chk("commit_valid", config_valid_b, 1);
    chk("commit_idle", busy_b, 0);
    chk("commit_err", error_b, 0);
    tick();
    chk("done_one_cycle", done_b, 0);
  endtask

  always @(negedge clock) begin
    if (done_b) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", done_b, 0);
      end else begin
        logic [96:0] e;
        e = exp_q.pop_front();
        chk("sb_cfg", config_out_b, e[95:0]);
        chk("sb_err", error_b, e[96]);
      end
    end
  end

  localparam logic [95:0] CFG_A = 96'h0B0A09080706050403020100;
  localparam logic [95:0] CFG_B = 96'h1B1A19181716151413121110;
  localparam logic [95:0] CFG_C = 96'h2B2A29282726252423222120;

  initial begin
    #2;
    chk("rst_cfg", config_out_b, 0);
    chk("rst_valid", config_valid_b, 0);
    chk("rst_ready", data_ready_b, 0);
    chk("rst_busy", busy_b, 0);
    chk("rst_done", done_b, 0);
    chk("rst_err", error_b, 0);
    chk("rst_state", state_dbg_b, 0);
    #10 reset = 1'b0;
    tick();

    // abort while idle does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy_b, 0);

    // basic load of 0x00..0x0B
    pulse_start_b();
    chk("load_busy", busy_b, 1);
    chk("load_ready", data_ready_b, 1);
    send_big(8'h00, 1'b1, 0, -1, -1, 1'b0);
    expect_commit(96'h0, CFG_A);

    // start pulse mid-load must not restart the word count
    pulse_start_b();
    send_big(8'h10, 1'b1, 0, 3, -1, 1'b0);
    expect_commit(CFG_A, CFG_B);

    // abort after 5 words of 0xAA, colliding with the 6th word
    pulse_start_b();
    send_big(8'hAA, 1'b0, 0, -1, 5, 1'b0);
    chk("abort_busy", busy_b, 0);
    chk("abort_cfg", config_out_b, CFG_B);
    chk("abort_done", done_b, 0);
    chk("abort_valid", config_valid_b, 1);
    tick();
    chk("abort_done_late", done_b, 0);

    // start and abort together in idle: start wins
    start_b = 1'b1;
    abort   = 1'b1;
    tick();
    start_b = 1'b0;
    abort   = 1'b0;
    chk("start_wins", busy_b, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", busy_b, 0);
    chk("abort_cfg2", config_out_b, CFG_B);

    // data_valid only every third cycle
    pulse_start_b();
    send_big(8'h20, 1'b1, 2, -1, -1, 1'b0);
    expect_commit(CFG_B, CFG_C);

`ifdef CONFIG_WORD_LOADER_CRC_EN
    pulse_start_b();
    send_big(8'h00, 1'b1, 0, -1, -1, 1'b0);
    expect_commit(CFG_C, CFG_A);

    pulse_start_b();
    send_big(8'h00, 1'b1, 0, -1, -1, 1'b1);
    exp_q.push_back({1'b1, CFG_A});
    tick();
    chk("crc_bad_done", done_b, 1);
    chk("crc_bad_err", error_b, 1);
    chk("crc_bad_cfg", config_out_b, CFG_A);
    chk("crc_bad_idle", busy_b, 0);
    tick();
    chk("crc_bad_done_low", done_b, 0);
    chk("crc_err_sticky", error_b, 1);
    pulse_start_b();
    chk("crc_err_cleared", error_b, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    // asynchronous reset in the middle of a load
    pulse_start_b();
    data_valid = 1'b1;
    data_in    = 8'h55;
    repeat (4) tick();
    #3 reset = 1'b1;
    #1;
    chk("arst_cfg", config_out_b, 0);
    chk("arst_valid", config_valid_b, 0);
    chk("arst_ready", data_ready_b, 0);
    chk("arst_busy", busy_b, 0);
    chk("arst_err", error_b, 0);
    data_valid = 1'b0;
    #2 reset = 1'b0;
    tick();

    // 18-bit instance: three 0xFF words, top 6 bits of word 2 dropped
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'hFF;
    repeat (3) begin
      chk("small_ready", data_ready_s, 1);
      tick();
    end
`ifdef CONFIG_WORD_LOADER_CRC_EN
    data_in = crc8_step(crc8_step(crc8_step(8'h00, 8'hFF), 8'hFF), 8'hFF);
    tick();
`endif
    data_valid = 1'b0;
    chk("small_no_partial", config_out_s, 0);
    chk("small_ready_low", data_ready_s, 0);
`ifdef CONFIG_WORD_LOADER_CRC_EN
    tick();
`endif
    tick();
    chk("small_cfg", config_out_s, 18'h3FFFF);
    chk("small_done", done_s, 1);
    chk("small_valid", config_valid_s, 1);
    chk("big_unaffected", busy_b, 0);
    tick();
    chk("small_done_low", done_s, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
